// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency instruction memory
// and presents fetched words via valid/ready. Optional perf counters: FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] addr_instr_mem,
  output logic              instruct_en,
  input  logic [DATA_W-1:0] instruction,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0] fetch_pc,
`ifdef FETCH_CTRL_PERF_EN
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic              resp_valid_reg;
  logic [ADDR_W-1:0] resp_pc_reg;
  logic              issue;
  logic              handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A redirect flushes the presented word, so it does not count as delivered when draining.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (halt) state_next = ST_DRAIN;
      ST_DRAIN: if (!resp_valid_reg || (handshake && !redirect_valid)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue       = (state_reg == ST_RUN) && !halt && !redirect_valid &&
                  (!resp_valid_reg || fetch_ready);
    instruct_en = issue;
    busy        = (state_reg != ST_IDLE);
  end

  assign handshake      = resp_valid_reg && fetch_ready;
  assign addr_instr_mem = pc_reg;
  assign fetch_valid    = resp_valid_reg;
  assign fetch_pc       = resp_pc_reg;
  assign fetch_instr    = instruction;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= ADDR_W'(RESET_PC);
      resp_valid_reg <= 1'b0;
      resp_pc_reg    <= '0;
    end else if (redirect_valid) begin
      pc_reg         <= redirect_addr;
      resp_valid_reg <= 1'b0;
    end else if (issue) begin
      pc_reg         <= pc_reg + ADDR_W'(1);
      resp_pc_reg    <= pc_reg;
      resp_valid_reg <= 1'b1;
    end else if (handshake) begin
      resp_valid_reg <= 1'b0;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] perf_fetched_reg;
  logic [15:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (handshake && (perf_fetched_reg != 16'hFFFF)) begin
        perf_fetched_reg <= perf_fetched_reg + 16'd1;
      end
      if (resp_valid_reg && !fetch_ready && (perf_stall_reg != 16'hFFFF)) begin
        perf_stall_reg <= perf_stall_reg + 16'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios then randomized control traffic,
// checked every cycle against a transaction-level reference model.
module tb_fetch_ctrl;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              fetch_ready = 1'b0;
  logic [ADDR_W-1:0] addr_instr_mem;
  logic              instruct_en;
  logic [DATA_W-1:0] instruction;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic [ADDR_W-1:0] fetch_pc;
  logic              busy;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0]       perf_fetched;
  logic [15:0]       perf_stall;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: mode is 0 idle, 1 running, 2 draining.
  int mode;
  int m_pc;
  int m_word_pc;
  bit m_word_valid;
  int m_fetched;
  int m_stall;

  fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .addr_instr_mem (addr_instr_mem),
    .instruct_en    (instruct_en),
    .instruction    (instruction),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
`ifdef FETCH_CTRL_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with registered read.
  always @(posedge clk) begin
    if (instruct_en) instruction <= mem[addr_instr_mem];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_issue();
    return (mode == 1) && !halt && !redirect_valid && (!m_word_valid || fetch_ready);
  endfunction

  task automatic model_check();
    check("instruct_en", 32'(instruct_en), 32'(model_issue()));
    check("addr", 32'(addr_instr_mem), 32'(m_pc));
    check("fetch_valid", 32'(fetch_valid), 32'(m_word_valid));
    check("fetch_pc", 32'(fetch_pc), 32'(m_word_pc));
    check("busy", 32'(busy), 32'(mode != 0));
    if (m_word_valid) check("fetch_instr", fetch_instr, mem[m_word_pc]);
`ifdef FETCH_CTRL_PERF_EN
    check("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
    check("perf_stall", 32'(perf_stall), 32'(m_stall));
`endif
  endtask

  // Advances the model by one clock using the inputs held across the edge.
  task automatic model_update();
    bit accepted;
    bit iss;
    if (rst) begin
      mode = 0; m_pc = 0; m_word_pc = 0; m_word_valid = 0;
      m_fetched = 0; m_stall = 0;
      return;
    end
    iss      = model_issue();
    accepted = m_word_valid && fetch_ready;
    if (accepted && m_fetched < 65535) m_fetched++;
    if (m_word_valid && !fetch_ready && m_stall < 65535) m_stall++;
    case (mode)
      0: if (start) mode = 1;
      1: if (halt) mode = 2;
      default: if (!m_word_valid || (accepted && !redirect_valid)) mode = 0;
    endcase
    if (redirect_valid) begin
      m_pc = int'(redirect_addr);
      m_word_valid = 0;
    end else if (iss) begin
      m_word_pc = m_pc;
      m_pc = (m_pc + 1) % DEPTH;
      m_word_valid = 1;
    end else if (accepted) begin
      m_word_valid = 0;
    end
  endtask

  task automatic drive(input bit s, input bit h, input bit rv, input int ra,
                       input bit rdy, input bit rs);
    start = s; halt = h; redirect_valid = rv; redirect_addr = ADDR_W'(ra);
    fetch_ready = rdy; rst = rs;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);

    rst = 1'b1;
    tick();

    drive(0, 0, 0, 0, 0, 0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_instruct_en", 32'(instruct_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(addr_instr_mem), 32'd0);
    tick();

    // Start, then stream with ready held high.
    drive(1, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("first_en", 32'(instruct_en), 32'd1);
    check("first_not_valid", 32'(fetch_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      check("stream_pc", 32'(fetch_pc), 32'(k));
      check("stream_instr", fetch_instr, 32'h100 + 32'(k));
      tick();
    end

    // Backpressure on word 5.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("bp_en", 32'(instruct_en), 32'd0);
      check("bp_pc", 32'(fetch_pc), 32'd5);
      check("bp_instr", fetch_instr, 32'h105);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    check("bp_accept_pc", 32'(fetch_pc), 32'd5);
    tick();
    for (int k = 6; k < 10; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      check("after_bp_pc", 32'(fetch_pc), 32'(k));
      tick();
    end

    // Redirect to 0x40 while word 10 is presented.
    drive(0, 0, 1, 'h40, 1, 0);
    check("redir_word10", 32'(fetch_pc), 32'd10);
    check("redir_no_issue", 32'(instruct_en), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("redir_no_stale", 32'(fetch_valid), 32'd0);
    check("redir_target_addr", 32'(addr_instr_mem), 32'h40);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("redir_pc40", 32'(fetch_pc), 32'h40);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("redir_pc41", 32'(fetch_pc), 32'h41);
    tick();

    // Redirect to the last word and wrap.
    drive(0, 0, 1, 'h7f, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("wrap_7f", 32'(fetch_pc), 32'h7f);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("wrap_00", 32'(fetch_pc), 32'h00);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("wrap_01", 32'(fetch_pc), 32'h01);
    tick();

    // Halt with word 2 pending and decode stalled.
    drive(0, 1, 0, 0, 0, 0);
    check("halt_en", 32'(instruct_en), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("drain_en", 32'(instruct_en), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_pc", 32'(fetch_pc), 32'd2);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("drain_deliver", 32'(fetch_valid), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(fetch_valid), 32'd0);
    tick();
    drive(1, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("resume_addr", 32'(addr_instr_mem), 32'd3);
    check("resume_en", 32'(instruct_en), 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("resume_pc", 32'(fetch_pc), 32'd3);
    tick();

    // Reset while running with a word presented.
    drive(0, 0, 0, 0, 0, 1);
    check("pre_rst_valid", 32'(fetch_valid), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("mid_rst_valid", 32'(fetch_valid), 32'd0);
    check("mid_rst_en", 32'(instruct_en), 32'd0);
    check("mid_rst_addr", 32'(addr_instr_mem), 32'd0);
`ifdef FETCH_CTRL_PERF_EN
    check("mid_rst_perf_fetched", 32'(perf_fetched), 32'd0);
    check("mid_rst_perf_stall", 32'(perf_stall), 32'd0);
`endif
    tick();

    // Randomized control traffic over fresh memory contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 6) == 0,
            ($urandom % 16) == 0,
            ($urandom % 10) == 0,
            (($urandom % 4) == 0) ? 127 : int'($urandom % DEPTH),
            ($urandom % 10) < 7,
            ($urandom % 200) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the single-cycle core. Owns the program counter and drives the synchronous instruction memory's address and enable. Tracks the memory's one-cycle read latency and presents each fetched word to decode through a valid/ready handshake. Supports start/halt control, branch/jump redirects, and backpressure without losing or duplicating instructions.

## Interface
Parameters:
- ADDR_W, 7: instruction-memory word-address width (128 words).
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching from the current PC when idle.
- halt  in  1  one-cycle pulse; stops issuing and drains the outstanding word.
- redirect_valid  in  1  loads a new PC this cycle.
- redirect_addr  in  ADDR_W  redirect target word address.
- addr_instr_mem  out  ADDR_W  memory word address; combinationally equal to PC.
- instruct_en  out  1  memory read enable; combinational.
- instruction  in  DATA_W  memory registered read data.
- fetch_valid  out  1  fetch_instr/fetch_pc hold a valid word.
- fetch_ready  in  1  decode accepts the word.
- fetch_instr  out  DATA_W  equal to `instruction`, qualified by fetch_valid.
- fetch_pc  out  ADDR_W  address of the presented word.
- busy  out  1  high in RUN or DRAIN.

## Operation
- Registers: pc, resp_valid, resp_pc, state. fetch_valid = resp_valid. fetch_pc = resp_pc.
- FSM states:
  - IDLE: start → RUN.
  - RUN: halt → DRAIN.
  - DRAIN: when resp_valid is 0, or the word is handshaken, → IDLE.
  - start is ignored outside IDLE. halt is ignored outside RUN.
- Issue condition: issue = (state==RUN) && !halt && !redirect_valid && (!resp_valid || fetch_ready). instruct_en = issue.
- On issue:
  - pc ← pc+1, wrapping modulo 2^ADDR_W (127 → 0).
  - resp_pc ← pc; resp_valid ← 1.
- Handshake without issue (fetch_valid && fetch_ready && !issue): resp_valid ← 0.
- Backpressure: while fetch_valid && !fetch_ready, instruct_en stays 0, so the memory output register holds the word. fetch_instr and fetch_pc stay stable until accepted.
- Redirect (any state):
  - pc ← redirect_addr; resp_valid ← 0 (the presented word is flushed even if fetch_ready is high).
  - No issue that cycle. Redirect has priority over issue and over handshake.
  - State is unchanged, except halt in the same RUN cycle still moves to DRAIN.
- Halt in RUN: no issue that cycle; the pending word, if any, is still presented and drained.
- The memory output is never trusted unless resp_valid is set; uninitialised data after reset is masked.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, resp_valid=0, resp_pc=0, instruct_en=0, fetch_valid=0, busy=0.
- Read latency: address issued with instruct_en at edge N; word visible with fetch_valid in the cycle after edge N.
- Throughput: one word per cycle while fetch_ready is held high.
- start at edge S: first instruct_en in cycle S+1; first fetch_valid in cycle S+2.
- Redirect penalty: redirect sampled at edge R; target issued in cycle R+1; target word valid in cycle R+2. No stale word appears between R and R+2.
- rst mid-operation: all state returns to reset values at the next edge, regardless of other inputs. The in-flight memory read is discarded.

## Configuration
- Macro: FETCH_CTRL_PERF_EN.
- Defined: adds outputs perf_fetched [15:0] and perf_stall [15:0].
  - perf_fetched counts handshakes (fetch_valid && fetch_ready).
  - perf_stall counts cycles with fetch_valid && !fetch_ready.
  - Both are saturating at 16'hFFFF and cleared by rst.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- Reset, start, fetch_ready=1, memory preloaded mem[i]=i+0x100 → fetch_pc 0,1,2,… on consecutive cycles; fetch_instr 0x100,0x101,…; first fetch_valid two cycles after start.
- Hold fetch_ready=0 for 3 cycles while pc_word 5 is presented → instruct_en=0, fetch_pc=5, fetch_instr=0x105 stable; on release, next word 6 follows the cycle after acceptance.
- redirect_valid with redirect_addr=0x40 while word 10 is presented → word 10 never handshaken; fetch_pc=0x40 valid two cycles later, then 0x41.
- Redirect to 0x7F and run → fetch_pc sequence 0x7F, 0x00, 0x01 (wrap).
- halt with word pending and fetch_ready=0 for 2 cycles → no further instruct_en; word delivered on ready; state IDLE and busy=0 the cycle after; a later start resumes at the next PC.
- Assert rst in RUN with fetch_valid=1 → next cycle fetch_valid=0, instruct_en=0, pc=RESET_PC. With FETCH_CTRL_PERF_EN, counters read 0.
